// File: rtl/block_stream_emitter.sv
// Serializes BEGIN/END/WORD token commands into a space-prefixed ASCII byte stream, one byte per clock,
// while tracking the nesting depth emitted so far and whether the stream is balanced.
module block_stream_emitter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [7:0]         cmd_char,
  input  logic [4:0]         case_mask,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow,
  output logic               balanced
);

  localparam logic [1:0] CMD_BEGIN = 2'b00;
  localparam logic [1:0] CMD_END   = 2'b01;
  localparam logic [1:0] CMD_WORD  = 2'b10;
  localparam logic [1:0] CMD_NOP   = 2'b11;

  typedef enum logic {IDLE, EMIT} state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [7:0]         char_q, char_d;
  logic [4:0]         mask_q, mask_d;
  logic [7:0]         out_q, out_d;
  logic               valid_q, valid_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               under_q, under_d;
  logic               over_q, over_d;
  logic               atLast;
  logic               xfer;

  function automatic logic [2:0] tokenLast(input logic [1:0] c);
    case (c)
      CMD_BEGIN: tokenLast = 3'd5;
      CMD_END:   tokenLast = 3'd3;
      default:   tokenLast = 3'd1;
    endcase
  endfunction

  // Keyword letter k sits at index k+1, so its case bit is mask[idx-1].
  function automatic logic [7:0] tokenChar(input logic [1:0] c, input logic [7:0] ch,
                                           input logic [4:0] m, input logic [2:0] idx);
    logic isLetter;
    tokenChar = 8'h20;
    isLetter  = 1'b0;
    case (c)
      CMD_BEGIN: begin
        isLetter = (idx != 3'd0);
        case (idx)
          3'd1:    tokenChar = 8'h62;
          3'd2:    tokenChar = 8'h65;
          3'd3:    tokenChar = 8'h67;
          3'd4:    tokenChar = 8'h69;
          3'd5:    tokenChar = 8'h6E;
          default: tokenChar = 8'h20;
        endcase
      end
      CMD_END: begin
        isLetter = (idx != 3'd0);
        case (idx)
          3'd1:    tokenChar = 8'h65;
          3'd2:    tokenChar = 8'h6E;
          3'd3:    tokenChar = 8'h64;
          default: tokenChar = 8'h20;
        endcase
      end
      CMD_WORD: begin
        if (idx == 3'd1) tokenChar = ch;
      end
      default: tokenChar = 8'h20;
    endcase
    if (isLetter && m[idx - 3'd1]) tokenChar = tokenChar - 8'h20;
  endfunction

  assign atLast    = (state_q == EMIT) && (idx_q == tokenLast(cmd_q));
  assign cmd_ready = (state_q == IDLE) || atLast;
  assign xfer      = cmd_valid && cmd_ready;

  always_comb begin
    state_d = IDLE;
    idx_d   = 3'd0;
    cmd_d   = cmd_q;
    char_d  = char_q;
    mask_d  = mask_q;
    out_d   = 8'h20;
    valid_d = 1'b0;
    depth_d = depth_q;
    under_d = under_q;
    over_d  = over_q;

    if (xfer) begin
      cmd_d  = cmd;
      char_d = cmd_char;
      mask_d = case_mask;
    end

    if (xfer && (cmd != CMD_NOP)) begin
      state_d = EMIT;
      out_d   = 8'h20;
      valid_d = 1'b1;
    end else if ((state_q == EMIT) && !atLast) begin
      state_d = EMIT;
      idx_d   = idx_q + 3'd1;
      out_d   = tokenChar(cmd_q, char_q, mask_q, idx_q + 3'd1);
      valid_d = 1'b1;
    end

    // Depth moves at acceptance time so the flags lead the emitted characters.
    if (xfer && (cmd == CMD_BEGIN)) begin
      if (depth_q == {DEPTH_W{1'b1}}) over_d = 1'b1;
      else                            depth_d = depth_q + DEPTH_W'(1);
    end else if (xfer && (cmd == CMD_END)) begin
      if (depth_q == '0) under_d = 1'b1;
      else               depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cmd_q   <= CMD_NOP;
      char_q  <= 8'h00;
      mask_q  <= 5'd0;
      out_q   <= 8'h20;
      valid_q <= 1'b0;
      depth_q <= '0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      char_q  <= char_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      depth_q <= depth_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign depth     = depth_q;
  assign underflow = under_q;
  assign overflow  = over_q;
  assign balanced  = (depth_q == '0) && !under_q;

endmodule

// File: tb/tb_block_stream_emitter.sv
// Randomized bench for block_stream_emitter: a string-level token model feeds an expected-byte queue
// and depth/flag model, checked every cycle; scenario tasks add directed checks.
module tb_block_stream_emitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] cmd_char;
  logic [4:0] case_mask;

  logic       cmdReady, outValid, underflow, overflow, balanced;
  logic [7:0] outChar;
  logic [7:0] depth;

  logic       cmdReady2, outValid2, underflow2, overflow2, balanced2;
  logic [7:0] outChar2;
  logic [1:0] depth2;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ[$];
  int         mDepth;
  bit         mUnder, mOver;
  bit         monEn;
  localparam int M_MAX = 255;

  block_stream_emitter #(.DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_char(cmd_char),
    .case_mask(case_mask), .cmd_ready(cmdReady), .out(outChar), .out_valid(outValid),
    .depth(depth), .underflow(underflow), .overflow(overflow), .balanced(balanced)
  );

  block_stream_emitter #(.DEPTH_W(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_char(cmd_char),
    .case_mask(case_mask), .cmd_ready(cmdReady2), .out(outChar2), .out_valid(outValid2),
    .depth(depth2), .underflow(underflow2), .overflow(overflow2), .balanced(balanced2)
  );

  always #5 clk = ~clk;

  task automatic modelXfer(input logic [1:0] c, input logic [7:0] ch, input logic [4:0] m);
    string      kw;
    logic [7:0] b;
    kw = (c == 2'b00) ? "begin" : (c == 2'b01) ? "end" : "";
    if (c == 2'b10) begin
      expQ.push_back(8'h20);
      expQ.push_back(ch);
    end else if (c != 2'b11) begin
      expQ.push_back(8'h20);
      for (int k = 0; k < kw.len(); k++) begin
        b = kw[k];
        if (m[k]) b = b - 8'h20;
        expQ.push_back(b);
      end
    end
    if (c == 2'b00) begin
      if (mDepth == M_MAX) mOver = 1'b1;
      else mDepth++;
    end else if (c == 2'b01) begin
      if (mDepth == 0) mUnder = 1'b1;
      else mDepth--;
    end
  endtask

  task automatic sendCmd(input logic [1:0] c, input logic [7:0] ch, input logic [4:0] m);
    int n = 0;
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_char  = ch;
    case_mask = m;
    while (cmdReady !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (cmdReady !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout cmd_ready=%b required 1", cmdReady);
    end else begin
      @(posedge clk); #1;
      modelXfer(c, ch, m);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic doReset;
    monEn     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 2'b11;
    cmd_char  = 8'h00;
    case_mask = 5'd0;
    #2 reset = 1'b0;
    expQ.delete();
    mDepth = 0; mUnder = 1'b0; mOver = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1 monEn = 1'b1;
  endtask

  task automatic monitor;
    logic [7:0] e;
    logic       expBal;
    forever begin
      @(negedge clk);
      if (monEn && reset === 1'b1) begin
        checks++;
        if (cmdReady !== (expQ.size() <= 1))
          begin errors++; $display("[TB] FAIL mon_ready got %b required %b", cmdReady, expQ.size() <= 1); end
        if (outValid === 1'b1) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++; $display("[TB] FAIL mon_stray got out=%h valid required idle", outChar);
          end else begin
            e = expQ.pop_front();
            if (outChar !== e) begin errors++; $display("[TB] FAIL mon_char got %h required %h", outChar, e); end
          end
        end else begin
          checks++;
          if (expQ.size() != 0 || outChar !== 8'h20)
            begin errors++; $display("[TB] FAIL mon_idle got out=%h valid=%b pending=%0d required stream", outChar, outValid, expQ.size()); end
        end
        expBal = (mDepth == 0) && !mUnder;
        checks++;
        if (depth !== 8'(mDepth) || underflow !== mUnder || overflow !== mOver || balanced !== expBal)
          begin errors++; $display("[TB] FAIL mon_flags got d=%0d u=%b o=%b b=%b required d=%0d u=%b o=%b b=%b",
                                   depth, underflow, overflow, balanced, mDepth, mUnder, mOver, expBal); end
      end
    end
  endtask

  task automatic test_reset;
    monEn = 1'b0;
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd = 2'b00;
    #3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outChar !== 8'h20 || outValid !== 1'b0 || cmdReady !== 1'b1 || depth !== 8'd0 ||
        underflow !== 1'b0 || overflow !== 1'b0 || balanced !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_vals got out=%h v=%b r=%b d=%0d u=%b o=%b b=%b required 20 0 1 0 0 0 1",
                               outChar, outValid, cmdReady, depth, underflow, overflow, balanced); end
    checks++;
    if (depth2 !== 2'd0 || outValid2 !== 1'b0 || balanced2 !== 1'b1 || cmdReady2 !== 1'b1)
      begin errors++; $display("[TB] FAIL reset_dut2 got d=%0d v=%b b=%b r=%b required 0 0 1 1", depth2, outValid2, balanced2, cmdReady2); end
    doReset();
  endtask

  task automatic test_begin_case;
    logic [7:0] want [6] = '{8'h20, 8'h62, 8'h65, 8'h67, 8'h69, 8'h4E};
    doReset();
    sendCmd(2'b00, 8'h00, 5'b10000);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (outValid !== 1'b1 || outChar !== want[i])
        begin errors++; $display("[TB] FAIL begin_char%0d got %h v=%b required %h", i, outChar, outValid, want[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (depth !== 8'd1 || balanced !== 1'b0)
      begin errors++; $display("[TB] FAIL begin_depth got d=%0d b=%b required 1 0", depth, balanced); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    string      want = " begin c enD";
    logic [7:0] got [12];
    logic       vld [12];
    doReset();
    sendCmd(2'b00, 8'h00, 5'b00000);
    fork
      begin
        sendCmd(2'b10, 8'h63, 5'b11111);
        sendCmd(2'b01, 8'h00, 5'b00100);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          got[i] = outChar;
          vld[i] = outValid;
          @(posedge clk); #1;
        end
      end
    join
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (vld[i] !== 1'b1 || got[i] !== 8'(want[i]))
        begin errors++; $display("[TB] FAIL b2b_char%0d got %h v=%b required %h", i, got[i], vld[i], 8'(want[i])); end
    end
    checks++;
    if (depth !== 8'd0 || balanced !== 1'b1 || outValid !== 1'b0)
      begin errors++; $display("[TB] FAIL b2b_end got d=%0d b=%b v=%b required 0 1 0", depth, balanced, outValid); end
  endtask

  task automatic test_underflow;
    doReset();
    sendCmd(2'b01, 8'h00, 5'b11000);
    checks++;
    if (underflow !== 1'b1 || depth !== 8'd0 || balanced !== 1'b0 || outValid !== 1'b1)
      begin errors++; $display("[TB] FAIL under_set got u=%b d=%0d b=%b v=%b required 1 0 0 1", underflow, depth, balanced, outValid); end
    repeat (4) @(posedge clk);
    #1;
    sendCmd(2'b00, 8'h00, 5'b00000);
    sendCmd(2'b01, 8'h00, 5'b00000);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (underflow !== 1'b1 || depth !== 8'd0 || balanced !== 1'b0)
      begin errors++; $display("[TB] FAIL under_sticky got u=%b d=%0d b=%b required 1 0 0", underflow, depth, balanced); end
  endtask

  task automatic test_overflow;
    int wantD;
    doReset();
    for (int i = 1; i <= 4; i++) begin
      sendCmd(2'b00, 8'h00, 5'b00000);
      wantD = (i < 3) ? i : 3;
      checks++;
      if (depth2 !== 2'(wantD) || overflow2 !== (i == 4))
        begin errors++; $display("[TB] FAIL ovf_step%0d got d=%0d o=%b required %0d %b", i, depth2, overflow2, wantD, i == 4); end
    end
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    doReset();
    sendCmd(2'b00, 8'h00, 5'b00000);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outChar !== 8'h67) begin errors++; $display("[TB] FAIL mid_pre got %h required 67", outChar); end
    monEn = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outChar !== 8'h20 || outValid !== 1'b0 || depth !== 8'd0 || cmdReady !== 1'b1 || balanced !== 1'b1)
      begin errors++; $display("[TB] FAIL mid_reset got out=%h v=%b d=%0d r=%b b=%b required 20 0 0 1 1",
                               outChar, outValid, depth, cmdReady, balanced); end
    expQ.delete();
    mDepth = 0; mUnder = 1'b0; mOver = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1 monEn = 1'b1;
    sendCmd(2'b01, 8'h00, 5'b00000);
    checks++;
    if (outValid !== 1'b1 || outChar !== 8'h20 || underflow !== 1'b1)
      begin errors++; $display("[TB] FAIL mid_after got out=%h v=%b u=%b required 20 1 1", outChar, outValid, underflow); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_nop;
    doReset();
    sendCmd(2'b00, 8'h00, 5'b00000);
    repeat (6) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cmdReady !== 1'b1 || outValid !== 1'b0 || depth !== 8'd1)
        begin errors++; $display("[TB] FAIL nop_%0d got r=%b v=%b d=%0d required 1 0 1", i, cmdReady, outValid, depth); end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_random;
    logic [1:0] c;
    doReset();
    for (int i = 0; i < 200; i++) begin
      c = 2'($urandom_range(0, 3));
      sendCmd(c, 8'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL rand_drain got %0d pending required 0", expQ.size()); end
  endtask

  initial begin
    monEn = 1'b0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 2'b11;
    cmd_char = 8'h00;
    case_mask = 5'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_begin_case();
    test_back_to_back();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_nop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
